// File: rtl/dec38_pulse.sv
// dec38_pulse: sequential 3-to-8 decoder.
// Buffers 3-bit codes in a small FIFO and replays each one as a registered
// one-hot strobe held for a programmable number of enabled cycles.
// Consecutive strobes are separated by exactly one all-zero cycle.
module dec38_pulse #(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [HOLD_W-1:0] hold,
    output logic [7:0]        dout,
    output logic              dout_valid,
    output logic              busy,
    output logic [CW-1:0]     count
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [7:0]        dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        fifo_mem [DEPTH];
    logic [2:0]        head;
    logic              push;
    logic              pop;

    assign din_ready  = (count_q != CW'(DEPTH));
    assign push       = din_valid && din_ready;
    assign head       = fifo_mem[rd_ptr_q];
    assign count      = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    // The strobe is masked while paused, without disturbing the registered value.
    assign dout       = en ? dout_q : 8'h00;
    assign dout_valid = en && dout_valid_q;

    // Strobe sequencing: pop a code from IDLE or GAP, hold it for the sampled length.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        pop          = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (en && (count_q != '0)) begin
                    pop          = 1'b1;
                    dout_d       = 8'd1 << head;
                    dout_valid_d = 1'b1;
                    cnt_d        = (hold == '0) ? '0 : hold - HOLD_W'(1);
                    state_d      = ACTIVE;
                end else begin
                    dout_d       = 8'h00;
                    dout_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            ACTIVE: begin
                if (en) begin
                    if (cnt_q == '0) begin
                        dout_d       = 8'h00;
                        dout_valid_d = 1'b0;
                        state_d      = GAP;
                    end else begin
                        cnt_d = cnt_q - HOLD_W'(1);
                    end
                end
            end
            default: begin
                dout_d       = 8'h00;
                dout_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // FIFO storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= din;
        end
    end

    // State, hold counter, registered strobe and FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_dec38_pulse.sv
// tb_dec38_pulse: directed bench for dec38_pulse with a strobe scoreboard.
// The stimulus thread queues every expected live strobe cycle; a monitor pops
// one entry per cycle in which the DUT presents dout_valid.
module tb_dec38_pulse;

    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [2:0]        din;
    logic              din_valid;
    logic [HOLD_W-1:0] hold;
    logic              din_ready;
    logic [7:0]        dout;
    logic              dout_valid;
    logic              busy;
    logic [2:0]        count;

    int         passed = 0;
    int         total  = 0;
    logic [7:0] sb_q[$];
    logic [7:0] sb_exp;
    logic [7:0] seq3 [5];

    dec38_pulse #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .hold       (hold),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic expect_strobe(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(v);
    endtask

    // Inputs change just after a rising edge; outputs are sampled on falling edges.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each live strobe cycle must match the next queued value.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                $display("[TB] FAIL sb_extra: got dout %0h, expected no strobe", dout);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_dout", {24'b0, dout}, {24'b0, sb_exp});
            end
        end
    end

    // A code offered as valid must be a known value.
    always @(posedge clk) begin
        if (rst_n && din_valid) begin
            assert (!$isunknown(din)) else $error("[TB] din unknown while din_valid high");
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        seq3 = '{8'h00, 8'h80, 8'h00, 8'h08, 8'h00};
        rst_n = 1'b0; en = 1'b0; din_valid = 1'b0; din = 3'd0; hold = '0;

        // Reset then idle
        @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_valid", dout_valid, 1'b0);
        check("rst_ready", din_ready, 1'b1);
        check("rst_count", count, 3'd0);
        check("rst_busy", busy, 1'b0);
        cyc(); cyc(); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_dout", dout, 8'h00);
            check("idle_busy", busy, 1'b0);
        end
        check("idle_ready", din_ready, 1'b1);
        check("idle_count", count, 3'd0);

        // Single code 5, hold 3
        cyc(); en = 1'b1; hold = 4'd3; din = 3'd5; din_valid = 1'b1;
        expect_strobe(8'h20, 3);
        cyc(); din_valid = 1'b0;
        @(negedge clk);
        check("single_count1", count, 3'd1);
        check("single_latency", dout, 8'h00);
        @(negedge clk);
        check("single_dout1", dout, 8'h20);
        check("single_busy", busy, 1'b1);
        check("single_count0", count, 3'd0);
        @(negedge clk);
        @(negedge clk);
        check("single_dout3", dout, 8'h20);
        @(negedge clk);
        check("single_gap", dout, 8'h00);
        check("single_gap_busy", busy, 1'b1);
        @(negedge clk);
        check("single_idle_busy", busy, 1'b0);
        check("single_drain", sb_q.size(), 0);

        // Back-to-back codes 0,7,3 with hold 0
        cyc(); hold = 4'd0; din = 3'd0; din_valid = 1'b1;
        expect_strobe(8'h01, 1); expect_strobe(8'h80, 1); expect_strobe(8'h08, 1);
        cyc(); din = 3'd7;
        cyc(); din = 3'd3;
        @(negedge clk);
        check("b2b_dout0", dout, 8'h01);
        cyc(); din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b2b_seq", dout, seq3[i]);
        end
        @(negedge clk);
        check("b2b_busy", busy, 1'b0);
        check("b2b_drain", sb_q.size(), 0);

        // Full FIFO with en low, then drain with hold 1
        cyc(); en = 1'b0; hold = 4'd1; din = 3'd1; din_valid = 1'b1;
        expect_strobe(8'h02, 1); expect_strobe(8'h04, 1);
        expect_strobe(8'h08, 1); expect_strobe(8'h10, 1);
        for (int k = 2; k <= 5; k++) begin
            cyc(); din = 3'(k);
        end
        @(negedge clk);
        check("full_count", count, 3'd4);
        check("full_ready", din_ready, 1'b0);
        cyc(); din_valid = 1'b0;
        @(negedge clk);
        check("full_refused", count, 3'd4);
        check("full_busy", busy, 1'b1);
        check("full_dout_off", dout, 8'h00);
        cyc(); en = 1'b1;
        cyc();
        @(negedge clk);
        check("full_first_pop_dout", dout, 8'h02);
        check("full_ready_after_pop", din_ready, 1'b1);
        check("full_count_after_pop", count, 3'd3);
        repeat (10) @(negedge clk);
        check("full_count_end", count, 3'd0);
        check("full_busy_end", busy, 1'b0);
        check("full_drain", sb_q.size(), 0);

        // Enable pause during a hold-4 strobe of code 6; hold changed mid-strobe
        cyc(); hold = 4'd4; din = 3'd6; din_valid = 1'b1;
        expect_strobe(8'h40, 4);
        cyc(); din_valid = 1'b0;
        cyc(); hold = 4'd9;
        @(negedge clk);
        check("pause_s1", dout, 8'h40);
        cyc();
        @(negedge clk);
        check("pause_s2", dout, 8'h40);
        cyc(); en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pause_dout", dout, 8'h00);
            check("pause_valid", dout_valid, 1'b0);
            check("pause_busy", busy, 1'b1);
            cyc();
        end
        en = 1'b1;
        @(negedge clk);
        check("pause_s3", dout, 8'h40);
        @(negedge clk);
        check("pause_s4", dout, 8'h40);
        @(negedge clk);
        check("pause_gap", dout, 8'h00);
        repeat (2) @(negedge clk);
        check("pause_busy_end", busy, 1'b0);
        check("pause_drain", sb_q.size(), 0);

        // Asynchronous reset mid-strobe with two codes still queued
        cyc(); hold = 4'd8; din = 3'd2; din_valid = 1'b1;
        expect_strobe(8'h04, 2);
        cyc(); din = 3'd3;
        cyc(); din = 3'd4;
        @(negedge clk);
        check("arst_count1", count, 3'd1);
        cyc(); din_valid = 1'b0;
        @(negedge clk);
        check("arst_pre_dout", dout, 8'h04);
        check("arst_pre_count", count, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dout", dout, 8'h00);
        check("arst_valid", dout_valid, 1'b0);
        check("arst_count", count, 3'd0);
        check("arst_ready", din_ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        cyc(); cyc(); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("arst_after_dout", dout, 8'h00);
        end
        check("arst_after_busy", busy, 1'b0);
        check("arst_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
